// File: rtl/wt_cache_pkg.sv
// Shared types and constants for the write-through dcache replacement logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wt_cache_pkg;

    // Re-reference prediction value width and the two insertion points.
    localparam int unsigned RRPV_WIDTH = 2;
    localparam logic [RRPV_WIDTH-1:0] RRPV_MAX  = {RRPV_WIDTH{1'b1}};
    localparam logic [RRPV_WIDTH-1:0] RRPV_LONG = RRPV_MAX - 1'b1;

    typedef logic [RRPV_WIDTH-1:0] rrpv_t;

    // Victim-search controller states.
    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } repl_state_e;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter: index of the first set bit from the LSB (MODE=0) or MSB (MODE=1).
// Latency: purely combinational.
// Backpressure: none; empty_o flags an all-zero input (cnt_o is then 0).
// Ports: in_i vector to scan, cnt_o zero count, empty_o no bit set.
module lzc #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    always_comb begin
        cnt_o = '0;
        if (MODE == 1'b0) begin
            // Scan downwards so the lowest set index is the last one written.
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(i);
            end
        end else begin
            // Scan upwards so the highest set index is the last one written.
            for (int i = 0; i < WIDTH; i++) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/wt_dcache_ship_repl.sv
// SHiP/SRRIP replacement: sets per-line RRPV on fill/hit and searches a set for an eviction victim.
// Latency: victim 1 cycle after request acceptance (invalid or distant way), up to 1+RRPV_MAX with aging.
// Backpressure: busy_o high while searching; vict_req_i is ignored then and must be held or re-issued.
// Ports: clk_i/rst_ni clock and async active-low reset; flush_i resets all RRPVs and aborts a search;
//        hit_* promotes a line to RRPV 0; fill_* inserts a line using pred_result_i (0 -> distant, else long);
//        vict_req_i/vict_set_i/vict_valid_ways_i start a search; busy_o, vict_vld_o, vict_way_o report it.
module wt_dcache_ship_repl
    import wt_cache_pkg::*;
#(
    parameter int unsigned NumSets   = 256,
    parameter int unsigned NumWays   = 8,
    parameter int unsigned RrpvWidth = RRPV_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       hit_i,
    input  logic [$clog2(NumSets)-1:0] hit_set_i,
    input  logic [$clog2(NumWays)-1:0] hit_way_i,
    input  logic                       fill_i,
    input  logic [$clog2(NumSets)-1:0] fill_set_i,
    input  logic [$clog2(NumWays)-1:0] fill_way_i,
    input  logic [1:0]                 pred_result_i,
    input  logic                       vict_req_i,
    input  logic [$clog2(NumSets)-1:0] vict_set_i,
    input  logic [NumWays-1:0]         vict_valid_ways_i,
    output logic                       busy_o,
    output logic                       vict_vld_o,
    output logic [$clog2(NumWays)-1:0] vict_way_o
);

    localparam int unsigned SetW = $clog2(NumSets);
    localparam int unsigned WayW = $clog2(NumWays);

    typedef logic [RrpvWidth-1:0] rrpv_w_t;
    localparam rrpv_w_t RrpvMax  = {RrpvWidth{1'b1}};
    localparam rrpv_w_t RrpvLong = RrpvMax - rrpv_w_t'(1);

    repl_state_e          state_q, state_d;
    logic [SetW-1:0]      set_q;
    logic [NumWays-1:0]   valid_q;
    logic [WayW-1:0]      way_q;
    rrpv_w_t              rrpv_q [NumSets][NumWays];

    logic [NumWays-1:0]   inval_mask;
    logic [NumWays-1:0]   max_mask;
    logic [WayW-1:0]      inval_idx;
    logic [WayW-1:0]      max_idx;
    logic [WayW-1:0]      pick_idx;
    logic                 inval_none;
    logic                 max_none;
    logic                 found;
    logic                 age;
    rrpv_w_t              fill_val;

    // ------------------------------------------------------------------
    // Victim selection on the latched set, using the live RRPVs so that
    // hits and fills landing mid-search are taken into account.
    // ------------------------------------------------------------------
    always_comb begin
        inval_mask = ~valid_q;
        max_mask   = '0;
        for (int w = 0; w < NumWays; w++) begin
            max_mask[w] = (rrpv_q[set_q][w] == RrpvMax);
        end
    end

    lzc #(
        .WIDTH     (NumWays),
        .MODE      (1'b0),
        .CNT_WIDTH (WayW)
    ) u_lzc_inval (
        .in_i    (inval_mask),
        .cnt_o   (inval_idx),
        .empty_o (inval_none)
    );

    lzc #(
        .WIDTH     (NumWays),
        .MODE      (1'b0),
        .CNT_WIDTH (WayW)
    ) u_lzc_max (
        .in_i    (max_mask),
        .cnt_o   (max_idx),
        .empty_o (max_none)
    );

    // Invalid ways take precedence over distant-RRPV ways.
    assign pick_idx = inval_none ? max_idx : inval_idx;
    assign found    = (state_q == SEARCH) && !(inval_none && max_none);
    // No way at RRPV_MAX here, so +1 cannot wrap.
    assign age      = (state_q == SEARCH) && inval_none && max_none;
    assign fill_val = (pred_result_i == 2'd0) ? RrpvMax : RrpvLong;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (vict_req_i) state_d = SEARCH;
                SEARCH:  if (found)      state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM: outputs. A flush in the deciding cycle suppresses the pulse.
    always_comb begin
        busy_o     = (state_q == SEARCH);
        vict_vld_o = found && !flush_i;
        vict_way_o = vict_vld_o ? pick_idx : way_q;
    end

    // ------------------------------------------------------------------
    // Request capture and last-victim hold register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            set_q   <= '0;
            valid_q <= '0;
            way_q   <= '0;
        end else begin
            if (state_q == IDLE && vict_req_i && !flush_i) begin
                set_q   <= vict_set_i;
                valid_q <= vict_valid_ways_i;
            end
            if (vict_vld_o) begin
                way_q <= pick_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // RRPV storage. Per-line priority: flush > fill > hit > aging.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NumSets; s++) begin
                for (int w = 0; w < NumWays; w++) begin
                    rrpv_q[s][w] <= RrpvMax;
                end
            end
        end else if (flush_i) begin
            for (int s = 0; s < NumSets; s++) begin
                for (int w = 0; w < NumWays; w++) begin
                    rrpv_q[s][w] <= RrpvMax;
                end
            end
        end else begin
            for (int s = 0; s < NumSets; s++) begin
                for (int w = 0; w < NumWays; w++) begin
                    if (fill_i && fill_set_i == SetW'(s) && fill_way_i == WayW'(w)) begin
                        rrpv_q[s][w] <= fill_val;
                    end else if (hit_i && hit_set_i == SetW'(s) && hit_way_i == WayW'(w)) begin
                        rrpv_q[s][w] <= '0;
                    end else if (age && set_q == SetW'(s)) begin
                        rrpv_q[s][w] <= rrpv_q[s][w] + rrpv_w_t'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wt_dcache_ship_repl.sv
module tb_wt_dcache_ship_repl;

    localparam int NS   = 256;
    localparam int NW   = 8;
    localparam int RMAX = 3;
    localparam int MS   = 16;   // sets tracked by the reference model

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       flush_i;
    logic       hit_i;
    logic [7:0] hit_set_i;
    logic [2:0] hit_way_i;
    logic       fill_i;
    logic [7:0] fill_set_i;
    logic [2:0] fill_way_i;
    logic [1:0] pred_result_i;
    logic       vict_req_i;
    logic [7:0] vict_set_i;
    logic [7:0] vict_valid_ways_i;
    logic       busy_o;
    logic       vict_vld_o;
    logic [2:0] vict_way_o;

    int checks = 0;
    int errors = 0;

    // Reference model: re-reference value of each line of the tracked sets.
    int m [MS][NW];

    always #5 clk_i = ~clk_i;

    wt_dcache_ship_repl #(
        .NumSets   (NS),
        .NumWays   (NW),
        .RrpvWidth (2)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .flush_i           (flush_i),
        .hit_i             (hit_i),
        .hit_set_i         (hit_set_i),
        .hit_way_i         (hit_way_i),
        .fill_i            (fill_i),
        .fill_set_i        (fill_set_i),
        .fill_way_i        (fill_way_i),
        .pred_result_i     (pred_result_i),
        .vict_req_i        (vict_req_i),
        .vict_set_i        (vict_set_i),
        .vict_valid_ways_i (vict_valid_ways_i),
        .busy_o            (busy_o),
        .vict_vld_o        (vict_vld_o),
        .vict_way_o        (vict_way_o)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_flush();
        for (int s = 0; s < MS; s++)
            for (int w = 0; w < NW; w++)
                m[s][w] = RMAX;
    endtask

    task automatic do_hit(input int s, input int w);
        hit_i = 1'b1; hit_set_i = 8'(s); hit_way_i = 3'(w);
        tick();
        hit_i = 1'b0;
        m[s][w] = 0;
    endtask

    task automatic do_fill(input int s, input int w, input int p);
        fill_i = 1'b1; fill_set_i = 8'(s); fill_way_i = 3'(w); pred_result_i = 2'(p);
        tick();
        fill_i = 1'b0;
        m[s][w] = (p == 0) ? RMAX : RMAX - 1;
    endtask

    // Issue a request and measure cycles from acceptance to vict_vld_o.
    // hw >= 0 drives a hit to (s, hw) during the first search cycle.
    task automatic run_req(input int s, input logic [7:0] mask, input int hw,
                           output int way, output int lat);
        vict_req_i = 1'b1; vict_set_i = 8'(s); vict_valid_ways_i = mask;
        tick();
        vict_req_i = 1'b0;
        if (hw >= 0) begin
            hit_i = 1'b1; hit_set_i = 8'(s); hit_way_i = 3'(hw);
        end
        lat = -1; way = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_i);
            if (vict_vld_o === 1'b1) begin
                lat = c; way = int'(vict_way_o);
                break;
            end
            @(posedge clk_i);
            #1;
            hit_i = 1'b0;
        end
        hit_i = 1'b0;
        tick();
    endtask

    // Request checked against the model: invalid way wins at once; otherwise
    // the set ages by (MAX - current max) and the first way at the max goes.
    task automatic check_req(input string tag, input int s, input logic [7:0] mask);
        int ew, el, k, mx, gw, gl;
        ew = -1; el = 1; k = 0;
        for (int w = NW - 1; w >= 0; w--) if (!mask[w]) ew = w;
        if (ew < 0) begin
            mx = 0;
            for (int w = 0; w < NW; w++) if (m[s][w] > mx) mx = m[s][w];
            k  = RMAX - mx;
            el = 1 + k;
            for (int w = NW - 1; w >= 0; w--) if (m[s][w] == mx) ew = w;
        end
        run_req(s, mask, -1, gw, gl);
        chk({tag, "_lat"}, gl, el);
        chk({tag, "_way"}, gw, ew);
        chk({tag, "_busy_after"}, int'(busy_o), 0);
        chk({tag, "_way_hold"}, int'(vict_way_o), ew);
        for (int w = 0; w < NW; w++) m[s][w] += k;
    endtask

    initial begin
        int gw, gl;
        rst_ni = 1'b0; flush_i = 1'b0; hit_i = 1'b0; hit_set_i = '0; hit_way_i = '0;
        fill_i = 1'b0; fill_set_i = '0; fill_way_i = '0; pred_result_i = '0;
        vict_req_i = 1'b0; vict_set_i = '0; vict_valid_ways_i = '0;
        model_flush();
        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_vld", int'(vict_vld_o), 0);
        chk("rst_way", int'(vict_way_o), 0);
        rst_ni = 1'b1;
        tick();

        // All lines start distant: way 0 immediately.
        check_req("s5_reset", 5, 8'hFF);
        // Invalid way 2 wins regardless of RRPVs.
        check_req("s3_invalid", 3, 8'b1111_1011);

        // All ways recently used: three aging steps.
        for (int w = 0; w < NW; w++) do_hit(7, w);
        check_req("s7_age", 7, 8'hFF);
        check_req("s7_after", 7, 8'hFF);

        // Fill distant, hit the rest, refill long: one aging step to way 4.
        do_fill(9, 4, 0);
        for (int w = 0; w < NW; w++) if (w != 4) do_hit(9, w);
        do_fill(9, 4, 2);
        check_req("s9_long", 9, 8'hFF);

        // Fill beats hit to the same line in the same cycle.
        for (int w = 0; w < NW; w++) do_hit(11, w);
        fill_i = 1'b1; fill_set_i = 8'd11; fill_way_i = 3'd2; pred_result_i = 2'd1;
        hit_i  = 1'b1; hit_set_i  = 8'd11; hit_way_i  = 3'd2;
        tick();
        fill_i = 1'b0; hit_i = 1'b0;
        m[11][2] = RMAX - 1;
        check_req("s11_fillwins", 11, 8'hFF);

        // Flush during an aging cycle aborts the search silently.
        for (int w = 0; w < NW; w++) do_hit(7, w);
        vict_req_i = 1'b1; vict_set_i = 8'd7; vict_valid_ways_i = 8'hFF;
        tick();
        vict_req_i = 1'b0;
        flush_i = 1'b1;
        @(negedge clk_i);
        chk("flush_no_vld", int'(vict_vld_o), 0);
        tick();
        flush_i = 1'b0;
        model_flush();
        chk("flush_busy", int'(busy_o), 0);
        @(negedge clk_i);
        chk("flush_no_vld_after", int'(vict_vld_o), 0);
        tick();
        check_req("s7_postflush", 7, 8'hFF);

        // Hit to way 0 during the first aging step keeps it young.
        for (int w = 0; w < NW; w++) do_hit(7, w);
        run_req(7, 8'hFF, 0, gw, gl);
        chk("hitage_lat", gl, 4);
        chk("hitage_way", gw, 1);
        for (int w = 1; w < NW; w++) m[7][w] = RMAX;
        m[7][0] = RMAX - 1;
        check_req("s7_hitage_after", 7, 8'hFF);

        // Randomized traffic on a few sets so operations collide.
        for (int i = 0; i < 60; i++) begin
            int op, s, w;
            logic [7:0] mask;
            op = $urandom_range(0, 3);
            s  = $urandom_range(0, 3);
            w  = $urandom_range(0, NW - 1);
            case (op)
                0, 1: do_hit(s, w);
                2:    do_fill(s, w, $urandom_range(0, 3));
                default: begin
                    mask = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
                    check_req($sformatf("rnd%0d", i), s, mask);
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
